// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the memory access sequencer.
// The optional timeout path is enabled with the MEM_TIMEOUT_EN macro.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_LOAD = 3'd2,
    ST_RD_HOLD = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  // Bits needed to hold 0..limit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle limiter for one memory request; only built when MEM_TIMEOUT_EN is defined.
// Loaded with TIMEOUT on request accept, counts down per cycle without mem_ready.
`ifdef MEM_TIMEOUT_EN
module mem_wait_timer
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic Clock,
  input  logic Clear,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] remain;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      remain <= '0;
    end else if (load) begin
      remain <= LIMIT;
    end else if (dec && (remain != '0)) begin
      remain <= remain - CW'(1);
    end
  end

  // Terminal count: TIMEOUT wait cycles have already elapsed in this request.
  assign expired = (remain == '0);

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// Sequences one RAM read or write between MAR/MDR and the memory array.
// Define MEM_TIMEOUT_EN to abort a request that waits more than TIMEOUT cycles.
//
// state   | meaning
// IDLE    | waiting for start_read / start_write
// RD_REQ  | mem_rd held until mem_ready
// RD_LOAD | Read=1, MDR mux settling on Mdatain
// RD_HOLD | Read=1, MDRin_mem=1, done=1
// WR_REQ  | mem_wr held until mem_ready
// FIN     | done=1 (write complete, or timeout with err=1)
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              start_read,
  input  logic              start_write,
  input  logic [31:0]       MAR_addr,
  input  logic [DATA_W-1:0] MDR_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Read,
  output logic              MDRin_mem,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state;
  logic   timeout_hit;

  // Upper MAR bits are outside the word-address space of this RAM.
  logic unused_ok;
  assign unused_ok = &{1'b0, MAR_addr[31:ADDR_W], 1'(TIMEOUT > 0)};

`ifdef MEM_TIMEOUT_EN
  logic in_req;
  logic accept;
  logic tmr_expired;

  assign in_req = (state == ST_RD_REQ) || (state == ST_WR_REQ);
  assign accept = (state == ST_IDLE) && (start_read || start_write);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .Clock   (Clock),
    .Clear   (Clear),
    .load    (accept),
    .dec     (in_req && !mem_ready),
    .expired (tmr_expired)
  );

  assign timeout_hit = in_req && tmr_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      Mdatain   <= '0;
      Read      <= 1'b0;
      MDRin_mem <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      MDRin_mem <= 1'b0;
      case (state)
        ST_IDLE: begin
          Read <= 1'b0;
          if (start_read) begin
            mem_addr <= MAR_addr[ADDR_W-1:0];
            mem_rd   <= 1'b1;
            state    <= ST_RD_REQ;
          end else if (start_write) begin
            mem_addr  <= MAR_addr[ADDR_W-1:0];
            mem_wdata <= MDR_data;
            mem_wr    <= 1'b1;
            state     <= ST_WR_REQ;
          end
        end
        ST_RD_REQ: begin
          // A response on the limit cycle still completes the read.
          if (mem_ready) begin
            Mdatain <= mem_rdata;
            mem_rd  <= 1'b0;
            Read    <= 1'b1;
            state   <= ST_RD_LOAD;
          end else if (timeout_hit) begin
            mem_rd <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
            state  <= ST_FIN;
          end
        end
        ST_RD_LOAD: begin
          Read      <= 1'b1;
          MDRin_mem <= 1'b1;
          done      <= 1'b1;
          state     <= ST_RD_HOLD;
        end
        ST_RD_HOLD: begin
          Read  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_WR_REQ: begin
          if (mem_ready) begin
            mem_wr <= 1'b0;
            done   <= 1'b1;
            state  <= ST_FIN;
          end else if (timeout_hit) begin
            mem_wr <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
            state  <= ST_FIN;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          Read   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a per-transaction timeline model.
// Timeout scenarios are exercised when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              Clock = 1'b0;
  logic              Clear;
  logic              start_read, start_write;
  logic [31:0]       MAR_addr;
  logic [DATA_W-1:0] MDR_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd, mem_wr, mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] Mdatain;
  logic              Read, MDRin_mem, busy, done, err;

  always #5 Clock = ~Clock;

  mem_access_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clock       (Clock),
    .Clear       (Clear),
    .start_read  (start_read),
    .start_write (start_write),
    .MAR_addr    (MAR_addr),
    .MDR_data    (MDR_data),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .Mdatain     (Mdatain),
    .Read        (Read),
    .MDRin_mem   (MDRin_mem),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]       exp_mdatain;
  logic [DATA_W-1:0] exp_wdata;
  logic [ADDR_W-1:0] exp_addr;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access: cycle 0 is the accept edge; the model derives every output's
  // expected window from the access type and the number of wait cycles.
  task automatic run_access(input bit is_rd, input bit both, input logic [31:0] mar,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int waits, input bit noise);
    int  strobe_end, done_c;
    bit  tmo;
    bit  ok_rd;
    tmo = 1'b0;
`ifdef MEM_TIMEOUT_EN
    tmo = (waits > TIMEOUT);
`endif
    ok_rd      = is_rd && !tmo;
    strobe_end = tmo ? TIMEOUT + 1 : waits + 1;
    done_c     = tmo ? TIMEOUT + 2 : (is_rd ? waits + 3 : waits + 2);

    @(negedge Clock);
    check_val("idle_busy", busy, 0);
    check_val("idle_done", done, 0);
    start_read  = is_rd;
    start_write = !is_rd || both;
    MAR_addr    = mar;
    MDR_data    = wd;
    mem_ready   = 1'b0;
    @(posedge Clock);
    #1;
    start_read  = 1'b0;
    start_write = 1'b0;
    exp_addr = mar[ADDR_W-1:0];
    if (!is_rd) exp_wdata = wd;

    for (int c = 1; c <= done_c; c++) begin
      @(negedge Clock);
      if (ok_rd && c == waits + 2) exp_mdatain = rd;
      check_val("mem_rd",    mem_rd,    is_rd && c <= strobe_end);
      check_val("mem_wr",    mem_wr,    !is_rd && c <= strobe_end);
      check_val("Read",      Read,      ok_rd && c >= waits + 2);
      check_val("MDRin_mem", MDRin_mem, ok_rd && c == done_c);
      check_val("done",      done,      c == done_c);
      check_val("err",       err,       tmo && c == done_c);
      check_val("busy",      busy,      1);
      check_val("mem_addr",  mem_addr,  exp_addr);
      check_val("mem_wdata", mem_wdata, exp_wdata);
      check_val("Mdatain",   Mdatain,   exp_mdatain);
      if (c <= strobe_end) begin
        mem_ready = (c == waits + 1);
        mem_rdata = (c == waits + 1) ? rd : $urandom;
      end else begin
        mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
      if (noise) begin
        start_read  = 1'($urandom_range(0, 1));
        start_write = 1'($urandom_range(0, 1));
      end
    end
    @(posedge Clock);
    #1;
    mem_ready   = 1'b0;
    start_read  = 1'b0;
    start_write = 1'b0;
  endtask

  task automatic clear_mid_read(input logic [31:0] mar);
    @(negedge Clock);
    start_read = 1'b1;
    MAR_addr   = mar;
    mem_ready  = 1'b0;
    @(posedge Clock);
    #1;
    start_read = 1'b0;
    @(negedge Clock);
    check_val("clr_pre_rd", mem_rd, 1);
    #2;
    Clear = 1'b1;
    #1;
    check_val("clr_mem_rd",  mem_rd,  0);
    check_val("clr_addr",    mem_addr, 0);
    check_val("clr_mdatain", Mdatain, 0);
    check_val("clr_wdata",   mem_wdata, 0);
    check_val("clr_busy",    busy, 0);
    check_val("clr_read",    Read, 0);
    exp_mdatain = '0;
    exp_wdata   = '0;
    @(negedge Clock);
    check_val("clr_done", done, 0);
    check_val("clr_mdrin", MDRin_mem, 0);
    @(posedge Clock);
    #1;
    Clear = 1'b0;
  endtask

  initial begin
    Clear       = 1'b1;
    start_read  = 1'b0;
    start_write = 1'b0;
    MAR_addr    = '0;
    MDR_data    = '0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    exp_mdatain = '0;
    exp_wdata   = '0;
    exp_addr    = '0;
    #12;
    check_val("rst_busy",    busy, 0);
    check_val("rst_mem_rd",  mem_rd, 0);
    check_val("rst_mem_wr",  mem_wr, 0);
    check_val("rst_done",    done, 0);
    check_val("rst_err",     err, 0);
    check_val("rst_mdatain", Mdatain, 0);
    check_val("rst_addr",    mem_addr, 0);
    @(posedge Clock);
    #1;
    Clear = 1'b0;

    run_access(1, 0, 32'h0000_0012, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_access(0, 0, 32'h0000_01FF, 32'h0000_00A5, 32'h0, 3, 0);
    run_access(1, 1, 32'h0000_0100, 32'h1234_5678, 32'hCAFE_F00D, 1, 1);
    clear_mid_read(32'h0000_0033);
    run_access(0, 0, 32'h0000_0044, 32'h5A5A_0001, 32'h0, 0, 0);
    run_access(1, 0, 32'hFFFF_FE01, 32'h0, 32'h0BAD_F00D, 2, 1);

`ifdef MEM_TIMEOUT_EN
    run_access(1, 0, 32'h0000_0077, 32'h0, 32'h1111_2222, TIMEOUT + 5, 0);
    run_access(1, 0, 32'h0000_0078, 32'h0, 32'h3333_4444, TIMEOUT, 0);
    run_access(0, 0, 32'h0000_0079, 32'hABCD_0000, 32'h0, TIMEOUT + 1, 1);
    run_access(0, 0, 32'h0000_007A, 32'hABCD_0001, 32'h0, TIMEOUT, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
